// File: rtl/input_repeat_scheduler.sv
// input_repeat_scheduler: DAS/ARR auto-repeat for left/right/down plus fixed-priority
// arbitration of button requests into a valid/ready command slot for the game FSM.
module input_repeat_scheduler #(
  parameter int DAS_CYCLES = 17000000,
  parameter int ARR_CYCLES = 5000000,
  parameter int CNT_W = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_press,
  input  logic [4:0] btn_release,
  input  logic       game_active,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [4:0] held
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_t;
  rep_t st [3];
  rep_t st_n [3];
  logic [CNT_W-1:0] cnt [3];
  logic [CNT_W-1:0] cnt_n [3];
  logic [4:0] pending, pend_next, clr;
  logic [2:0] fire, ovr, rel_o, sel_code;
  logic load, any;
  // left and right knock each other out; down has no partner
  assign ovr   = {1'b0, btn_press[0], btn_press[1]};
  assign rel_o = {1'b0, btn_release[0], btn_release[1]};
  always_comb begin
    fire = '0;
    for (int i = 0; i < 3; i++) begin
      st_n[i] = st[i];
      cnt_n[i] = '0;
      if (btn_release[i]) st_n[i] = IDLE;
      else if (btn_press[i]) st_n[i] = DELAY;
      else if (ovr[i]) st_n[i] = IDLE;
      else if (rel_o[i] && held[i] && st[i] == IDLE) st_n[i] = DELAY;
      else if (st[i] == IDLE) st_n[i] = IDLE;
      else if (st[i] == DELAY ? cnt[i] == CNT_W'(DAS_CYCLES - 1) : cnt[i] == CNT_W'(ARR_CYCLES - 1)) begin
        fire[i] = 1'b1;
        st_n[i] = REPEAT;
      end else cnt_n[i] = cnt[i] + 1'b1;
    end
  end
  assign sel_code = pending[4] ? 3'd4 : pending[3] ? 3'd3 : pending[0] ? 3'd0 : pending[1] ? 3'd1 : 3'd2;
  assign any = |pending;
  assign load = !cmd_valid || cmd_ready;
  assign clr = (load && any) ? 5'(5'd1 << sel_code) : 5'd0;
  // fresh requests win over the clear caused by loading the same button
  assign pend_next = (pending & ~clr & ~{3'b0, ovr[1:0]}) | btn_press | {2'b0, fire};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      held <= '0;
      pending <= '0;
      cmd_valid <= 1'b0;
      cmd_code <= '0;
      for (int i = 0; i < 3; i++) begin
        st[i] <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      held <= (held | btn_press) & ~btn_release;
      pending <= game_active ? pend_next : '0;
      cmd_valid <= game_active && (load ? any : cmd_valid);
      if (game_active && load && any) cmd_code <= sel_code;
      for (int i = 0; i < 3; i++) begin
        st[i] <= game_active ? st_n[i] : IDLE;
        cnt[i] <= game_active ? cnt_n[i] : '0;
      end
    end
endmodule
